// File: rtl/led_seg_arbiter_pkg.sv
// Shared types and constants for the LED / 7-segment display arbiter.
package led_seg_arbiter_pkg;

  localparam int N_CLIENTS = 3;
  localparam logic [7:0] LED_DARK = 8'h00;
  localparam logic [7:0] SEG_DARK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OWN
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [N_CLIENTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_seg_arbiter_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, last (mod 3).
module rr_pick
  import led_seg_arbiter_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
  input  logic [1:0]           last,
  output logic [N_CLIENTS-1:0] winner,
  output logic                 valid
);

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = last;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = next_idx(idx);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/led_seg_arbiter.sv
// Three-client arbiter sharing one LED bank and one 7-segment digit.
// Optional pre-emption of long contended grants: define ARB_TIMEOUT_EN.
module led_seg_arbiter
  import led_seg_arbiter_pkg::*;
#(
  parameter logic [31:0] MIN_HOLD = 32'd25_000_000,
  parameter logic [31:0] MAX_HOLD = 32'd250_000_000
) (
  input  logic                   fpga_clk_50,
  input  logic                   fpga_rst_n,
  input  logic [N_CLIENTS-1:0]   req_i,
  input  logic [8*N_CLIENTS-1:0] led_i,
  input  logic [8*N_CLIENTS-1:0] seg_i,
  output logic [N_CLIENTS-1:0]   grant_o,
  output logic [7:0]             usr_led_o,
  output logic [7:0]             usr_seg_o,
  output logic                   busy_o
);

  if (MAX_HOLD <= MIN_HOLD) begin : g_bad_hold
    $error("MAX_HOLD must exceed MIN_HOLD");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [31:0] CNT_SAT = MAX_HOLD - 32'd1;
`else
  localparam logic [31:0] CNT_SAT = MIN_HOLD - 32'd1;
`endif

  arb_state_e             state_q, state_d;
  logic [N_CLIENTS-1:0]   grant_d;
  logic [31:0]            hold_cnt_q, hold_cnt_d, hold_cnt_inc;
  logic [1:0]             last_q, last_d;
  logic [N_CLIENTS-1:0]   rr_winner;
  logic                   rr_valid;
  logic                   holder_req;
  logic                   release_grant;
  logic [7:0]             led_sel_p0, seg_sel_p0;

  rr_pick u_rr_pick (
    .req    (req_i),
    .last   (last_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  assign holder_req   = |(req_i & grant_o);
  assign hold_cnt_inc = (hold_cnt_q == CNT_SAT) ? hold_cnt_q : hold_cnt_q + 32'd1;

`ifdef ARB_TIMEOUT_EN
  assign release_grant = !holder_req ||
                         ((hold_cnt_q == MAX_HOLD - 32'd1) && |(req_i & ~grant_o));
`else
  assign release_grant = !holder_req;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_o;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d    = rr_winner;
          hold_cnt_d = '0;
          last_d     = onehot_to_idx(rr_winner);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_inc;
        if (hold_cnt_q == MIN_HOLD - 32'd1) state_d = OWN;
      end
      OWN: begin
        hold_cnt_d = hold_cnt_inc;
        // Release wins over any pending request; arbitration waits for IDLE.
        if (release_grant) begin
          grant_d    = '0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q    <= IDLE;
      grant_o    <= '0;
      hold_cnt_q <= '0;
      last_q     <= 2'd2;
    end else begin
      state_q    <= state_d;
      grant_o    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  // Stage p0: select the holder's slice from the current grant
  always_comb begin
    led_sel_p0 = LED_DARK;
    seg_sel_p0 = SEG_DARK;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_o[i]) begin
        led_sel_p0 = led_i[8*i +: 8];
        seg_sel_p0 = seg_i[8*i +: 8];
      end
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      usr_led_o <= LED_DARK;
      usr_seg_o <= SEG_DARK;
    end else begin
      usr_led_o <= led_sel_p0;
      usr_seg_o <= seg_sel_p0;
    end
  end

  assign busy_o = |grant_o;

endmodule
